// File: rtl/ram_stream_reader_if.sv
// Read-port and output-stream bundle for ram_stream_reader.
// master = reader side (drives RAM read port and stream), slave = RAM/sink side.
interface ram_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             re_enb;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] mem_data;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (
    output re_enb, rd_addr, m_valid, m_data, m_last,
    input  mem_data, m_ready
  );

  modport slave (
    input  re_enb, rd_addr, m_valid, m_data, m_last,
    output mem_data, m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader: turns one (base_addr, length) command into RAM reads and a valid/ready stream.
// Optional abort input is built only when RDR_ABORT_EN is defined.
module ram_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
`ifdef RDR_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  ram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LEN_ZERO = (AW+1)'(0);

  state_t           state_r, state_s;
  logic [AW:0]      len_sat_s, left_r, left_s;
  logic [AW-1:0]    next_addr_r, next_addr_s, rd_addr_r, rd_addr_s;
  logic             re_enb_r, re_enb_s, re_last_r, re_last_s;
  logic             cap_r, cap_last_r;
  logic             busy_r, busy_s, done_r, done_s;
  logic [1:0]       occ_r, occ_s;
  logic [WIDTH-1:0] data_r [3];
  logic [WIDTH-1:0] data_s [3];
  logic [2:0]       last_r, last_s;
  logic             m_valid_r, m_last_r;
  logic             abort_req_s, abort_s, accept_s, zero_len_s;
  logic             pop_s, push_s, room_s, drained_s, issue_s;
  logic [2:0]       level_s;

`ifdef RDR_ABORT_EN
  assign abort_req_s = abort;
`else
  assign abort_req_s = 1'b0;
`endif

  assign abort_s    = abort_req_s & (state_r != ST_IDLE);
  assign accept_s   = (state_r == ST_IDLE) & start & ~abort_req_s;
  assign len_sat_s  = (length > LEN_MAX) ? LEN_MAX : length;
  assign zero_len_s = (len_sat_s == LEN_ZERO);
  assign pop_s      = m_valid_r & bus.m_ready;
  assign push_s     = cap_r & ~abort_s;

  // Buffered words plus both read-pipeline stages must never exceed the 3 slots.
  assign level_s    = {1'b0, occ_r} + {2'b00, re_enb_r} + {2'b00, cap_r} - {2'b00, pop_s};
  assign room_s     = (level_s < 3'd3);
  assign drained_s  = ~re_enb_r & ~cap_r & (occ_r == {1'b0, pop_s});
  assign issue_s    = accept_s ? ~zero_len_s : ((state_r == ST_READ) & ~abort_s & room_s);

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s & ~zero_len_s) begin
          state_s = (len_sat_s == LEN_ONE) ? ST_DRAIN : ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (issue_s & (left_r == LEN_ONE)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (abort_s | drained_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs and read-address generation (next values of registered outputs)
  always_comb begin
    busy_s      = (state_s != ST_IDLE);
    done_s      = abort_s | (accept_s & zero_len_s) | ((state_r == ST_DRAIN) & drained_s);
    re_enb_s    = issue_s;
    rd_addr_s   = rd_addr_r;
    re_last_s   = 1'b0;
    left_s      = left_r;
    next_addr_s = next_addr_r;
    if (abort_s) begin
      left_s = LEN_ZERO;
    end else if (accept_s & ~zero_len_s) begin
      rd_addr_s   = base_addr;
      next_addr_s = base_addr + AW'(1);
      left_s      = len_sat_s - LEN_ONE;
      re_last_s   = (len_sat_s == LEN_ONE);
    end else if (issue_s) begin
      rd_addr_s   = next_addr_r;
      next_addr_s = next_addr_r + AW'(1);
      left_s      = left_r - LEN_ONE;
      re_last_s   = (left_r == LEN_ONE);
    end else begin
      left_s = left_r;
    end
  end

  // Control registers and the two-stage read-return pipeline
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      re_enb_r    <= 1'b0;
      re_last_r   <= 1'b0;
      rd_addr_r   <= {AW{1'b0}};
      next_addr_r <= {AW{1'b0}};
      left_r      <= LEN_ZERO;
      cap_r       <= 1'b0;
      cap_last_r  <= 1'b0;
    end else begin
      busy_r      <= busy_s;
      done_r      <= done_s;
      re_enb_r    <= re_enb_s;
      re_last_r   <= re_last_s;
      rd_addr_r   <= rd_addr_s;
      next_addr_r <= next_addr_s;
      left_r      <= left_s;
      cap_r       <= re_enb_r & ~abort_s;
      cap_last_r  <= re_last_r;
    end
  end

  // Shift FIFO: slot 0 is the stream output, so m_data never moves while stalled
  always_comb begin
    data_s = data_r;
    last_s = last_r;
    occ_s  = occ_r;
    if (abort_s) begin
      occ_s = 2'd0;
    end else begin
      if (pop_s) begin
        data_s[0] = data_r[1];
        data_s[1] = data_r[2];
        last_s    = {1'b0, last_r[2:1]};
        occ_s     = occ_r - 2'd1;
      end else begin
        occ_s = occ_r;
      end
      if (push_s) begin
        case (occ_s)
          2'd0: begin
            data_s[0] = bus.mem_data;
            last_s[0] = cap_last_r;
            occ_s     = 2'd1;
          end
          2'd1: begin
            data_s[1] = bus.mem_data;
            last_s[1] = cap_last_r;
            occ_s     = 2'd2;
          end
          2'd2: begin
            data_s[2] = bus.mem_data;
            last_s[2] = cap_last_r;
            occ_s     = 2'd3;
          end
          default: occ_s = 2'd3;
        endcase
      end else begin
        last_s = last_s;
      end
    end
  end

  // FIFO storage and registered stream outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ_r     <= 2'd0;
      last_r    <= 3'd0;
      data_r[0] <= {WIDTH{1'b0}};
      data_r[1] <= {WIDTH{1'b0}};
      data_r[2] <= {WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      occ_r     <= occ_s;
      last_r    <= last_s;
      data_r[0] <= data_s[0];
      data_r[1] <= data_s[1];
      data_r[2] <= data_s[2];
      m_valid_r <= (occ_s != 2'd0);
      m_last_r  <= last_s[0] & (occ_s != 2'd0);
    end
  end

  assign bus.re_enb  = re_enb_r;
  assign bus.rd_addr = rd_addr_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = data_r[0];
  assign bus.m_last  = m_last_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a scoreboard of expected words/addresses
// is filled by the stimulus and drained by an independent negedge monitor.
module tb_ram_stream_reader;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;
`ifdef RDR_ABORT_EN
  logic       abort;
`endif

  ram_stream_reader_if #(.WIDTH(8), .AW(4)) bus ();

  ram_stream_reader #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef RDR_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic [8:0] exp_q [$];
  logic [3:0] addr_q [$];
  int         issued;
  int         popped;
  bit         stall_prev;
  logic [8:0] prev_word;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_word(input logic [3:0] a);
    return {4'h0, a} + 8'h10;
  endfunction

  // RAM read port: one-cycle registered read
  always @(posedge clock) begin
    if (bus.re_enb) bus.mem_data <= mem_word(bus.rd_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_clear();
    exp_q.delete();
    addr_q.delete();
    issued     = 0;
    popped     = 0;
    stall_prev = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] base, input int sat);
    logic [3:0] a;
    for (int i = 0; i < sat; i++) begin
      a = base + i[3:0];
      exp_q.push_back({(i == sat - 1), mem_word(a)});
      addr_q.push_back(a);
    end
  endtask

  function automatic logic ready_for(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (n >= 6 && n <= 10) return 1'b0;
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  // Monitor: read-address scoreboard, outstanding bound, stall stability, word scoreboard
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.re_enb) begin
        vectors++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got addr %0h expected no read at %0t", bus.rd_addr, $time);
        end else begin
          check("rd_addr", {28'd0, bus.rd_addr}, {28'd0, addr_q.pop_front()});
        end
        issued++;
        check("outstanding_le3", {31'd0, (issued - popped) > 3}, 32'd0);
      end
      if (bus.m_valid) begin
        if (stall_prev) check("stall_stable", {23'd0, bus.m_last, bus.m_data}, {23'd0, prev_word});
        if (bus.m_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", {bus.m_last, bus.m_data}, $time);
          end else begin
            check("word", {23'd0, bus.m_last, bus.m_data}, {23'd0, exp_q.pop_front()});
          end
          popped++;
        end
      end
      stall_prev = bus.m_valid & ~bus.m_ready;
      prev_word  = {bus.m_last, bus.m_data};
    end
  end

  task automatic run_burst(input logic [3:0] base, input logic [4:0] len, input int mode,
                           input int exp_done, input bit poke);
    int n, sat, first_v, done_n;
    sat = (len > 5'd16) ? 16 : int'(len);
    push_exp(base, sat);
    start     = 1'b1;
    base_addr = base;
    length    = len;
    tick();
    start     = 1'b0;
    base_addr = ~base;
    length    = 5'd9;
    n = 0; first_v = -1; done_n = -1;
    check("busy_after_start", {31'd0, busy}, {31'd0, sat != 0});
    if (done) done_n = 0;
    while (done_n < 0 && n < 300) begin
      bus.m_ready = ready_for(mode, n);
      if (poke && n == 1) begin
        start = 1'b1; base_addr = 4'd5; length = 5'd3;
      end
      tick();
      n++;
      start = 1'b0;
      if (bus.m_valid && first_v < 0) first_v = n;
      if (done) done_n = n;
    end
    if (done_n < 0) begin
      vectors++; errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles (base %0h len %0d)", base, len);
    end
    if (exp_done >= 0) begin
      check("done_cycle", done_n, exp_done);
      if (sat > 0) check("first_valid_cycle", first_v, 32'd2);
    end
    check("busy_at_done", {31'd0, busy}, 32'd0);
    bus.m_ready = 1'b1;
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("words_left", exp_q.size(), 32'd0);
    check("reads_left", addr_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_done"},    {31'd0, done}, 32'd0);
    check({tag, "_re_enb"},  {31'd0, bus.re_enb}, 32'd0);
    check({tag, "_rd_addr"}, {28'd0, bus.rd_addr}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
    check({tag, "_m_data"},  {24'd0, bus.m_data}, 32'd0);
    check({tag, "_m_last"},  {31'd0, bus.m_last}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start = 1'b0; base_addr = 4'd0; length = 5'd0;
    bus.m_ready = 1'b1;
`ifdef RDR_ABORT_EN
    abort = 1'b0;
`endif
    sb_clear();
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tick();

    run_burst(4'd2,  5'd4,  0, 6,  1'b0);   // basic: 12,13,14,15
    run_burst(4'd14, 5'd4,  0, 6,  1'b0);   // wrap: 14,15,0,1
    run_burst(4'd5,  5'd8,  1, -1, 1'b0);   // backpressure
    run_burst(4'd3,  5'd0,  0, 0,  1'b0);   // zero length
    run_burst(4'd3,  5'd31, 0, 18, 1'b0);   // saturates to 16 words
    run_burst(4'd0,  5'd4,  0, 6,  1'b1);   // start while busy ignored
    repeat (4) tick();
    check("idle_after_poke", {31'd0, busy}, 32'd0);

    // Reset in the middle of an 8-word burst
    push_exp(4'd0, 8);
    start = 1'b1; base_addr = 4'd0; length = 5'd8;
    tick();
    start = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_clear();
    @(posedge clock);
    #1 resetn = 1'b1;
    tick();
    run_burst(4'd9, 5'd3, 0, 5, 1'b0);

`ifdef RDR_ABORT_EN
    push_exp(4'd0, 10);
    bus.m_ready = 1'b0;
    start = 1'b1; base_addr = 4'd0; length = 5'd10;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("abort_re_enb",  {31'd0, bus.re_enb}, 32'd0);
    check("abort_busy",    {31'd0, busy}, 32'd0);
    check("abort_done",    {31'd0, done}, 32'd1);
    sb_clear();
    tick();
    check("abort_done_pulse", {31'd0, done}, 32'd0);
    repeat (3) tick();
    bus.m_ready = 1'b1;
    run_burst(4'd1, 5'd2, 0, 4, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side streaming controller for the dual-port RAM. A single command (base address, word count) makes it drive the RAM read port (`re_enb`/`rd_addr`) and turn the returned words into a valid/ready stream. A small internal buffer absorbs the RAM read latency and downstream backpressure without losing or duplicating words. It is the consumer counterpart to the RAM write path and sits between the RAM and any downstream stream sink.

## Interface
- `WIDTH`, 8, data word width; must match the RAM.
- `DEPTH`, 16, RAM depth in words; must be a power of two.
- `AW`, 4, address width, log2(`DEPTH`).

Ports:
- `clock` input 1: sole clock; all logic samples on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `base_addr` input AW: first RAM address of the burst.
- `length` input AW+1: number of words. 0 is a no-op. Values above `DEPTH` saturate to `DEPTH`.
- `busy` output 1: high in READ and DRAIN.
- `done` output 1: one-cycle pulse at burst completion.
- `re_enb` output 1: RAM read enable (registered).
- `rd_addr` output AW: RAM read address (registered).
- `mem_data` input WIDTH: RAM `data_out`, valid one edge after the edge at which the RAM samples `re_enb`.
- `m_valid` output 1: stream word valid.
- `m_data` output WIDTH: stream word.
- `m_last` output 1: marks the final word of the burst.
- `m_ready` input 1: sink ready; a handshake occurs when `m_valid` and `m_ready` are both high at an edge.
- `abort` input 1: present only with `RDR_ABORT_EN`.

## Operation
- **FSM states:**
  - IDLE: `start` with `length`≠0 goes to READ. `start` with `length`=0 pulses `done` next cycle, issues no reads and stays in IDLE.
  - READ: issues reads. After the last read is issued, goes to DRAIN.
  - DRAIN: waits until all in-flight and buffered words have been handshaked, then returns to IDLE with a `done` pulse.
- **Address generation:** `rd_addr` = (`base_addr` + i) mod `DEPTH`, i = 0..L-1, so addresses wrap from `DEPTH`-1 to 0.
- **Buffer:** 3-entry FIFO, sized to cover 2 cycles of read pipeline plus 1 output word.
- **Issue rule:** a read is issued at an edge only when (occupancy + reads in flight − pop at this edge) < 3. The buffer never overflows, and no `mem_data` sample is ever dropped.
- **Capture:** `mem_data` is captured only in the slot corresponding to an issued read. The RAM's hold value is never re-captured.
- **Stream stability:** while `m_valid` is high and `m_ready` is low, `m_data` and `m_last` are stable. Words are emitted in address order.
- **`m_last`:** asserted with word L-1 only.
- **`start` while busy:** ignored. The command inputs are latched at the accepting edge, so they may change afterwards.
- **Reset (including mid-burst):** immediately sets `busy`, `done`, `re_enb`, `m_valid` and `m_last` to 0, and `rd_addr` and `m_data` to 0. The FSM returns to IDLE and the buffer and counters clear. No `done` is generated for the interrupted burst.

## Timing
- `start` accepted at edge t: `re_enb`=1 with `rd_addr`=base from edge t.
- `mem_data` is valid from edge t+1.
- `m_valid` rises at edge t+2. Latency is 2 cycles.
- With `m_ready` held high:
  - One word per cycle, with no bubbles.
  - The last handshake is at edge t+2+L.
  - `busy` falls at that same edge.
  - `done` is high for the cycle after that edge.
- `re_enb` stays low whenever the issue rule fails. It resumes on the edge after room frees.
- A new `start` is accepted in the cycle `done` is high, since the FSM is already in IDLE.

## Configuration
- **`RDR_ABORT_EN` defined:** the `abort` port exists.
  - `abort` high at an edge while busy:
    - `re_enb` deasserts from that edge.
    - In-flight returns are discarded.
    - The buffer is flushed, so `m_valid`=0 from that edge.
    - The FSM goes to IDLE.
    - `done` pulses in the following cycle.
  - `abort` in IDLE is ignored. `abort` wins over a simultaneous `start`.
- **`RDR_ABORT_EN` undefined:** no `abort` port; every accepted burst runs to completion.

## Test plan
- **Basic burst:** mem[i]=i+8'h10, `start` with base=2, L=4, `m_ready`=1 -> `m_data` 12,13,14,15 on consecutive cycles from t+2; `m_last` on 15; `done` one cycle after the last handshake.
- **Wrap-around:** base=14, L=4 -> addresses 14,15,0,1 in that order.
- **Backpressure:** L=8 with `m_ready` toggled 1,0,0,1… and held low for 5 cycles -> all 8 words in order, none duplicated; `re_enb` stalls while the buffer is full; `m_data` is stable while stalled.
- **Length edge cases:**
  - L=0 -> `done` pulse with no `re_enb`.
  - L=31 -> exactly 16 words.
  - `start` while busy -> ignored.
- **Reset mid-burst:** `resetn` low at word 3 of 8 -> all outputs 0 immediately; a new burst after release behaves normally.
- **Abort (`RDR_ABORT_EN`):** `abort` at word 2 of 10 with `m_ready` low -> `m_valid` drops, no further `re_enb`, `done` on the next cycle.
